// File: rtl/fft_pkg.sv
// Shared definitions for the FFT datapath blocks.
//   FFT_DATA_WIDTH : default signed operand/result width
//   FFT_TRUNC      : default number of LSBs dropped from full-precision products
//   id_width()     : width of a requester index, never less than one bit
package fft_pkg;

  localparam int FFT_DATA_WIDTH = 16;
  localparam int FFT_TRUNC      = 8;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/complex_multiplier.sv
// Combinational signed complex multiplier.
//   a_real/a_imag, b_real/b_imag : signed operands, DATA_WIDTH bits each
//   p_real/p_imag                : bits [DATA_WIDTH-1+TRUNC:TRUNC] of the
//                                  2*DATA_WIDTH-bit product (truncating, wrapping)
module complex_multiplier
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = FFT_DATA_WIDTH,
  parameter int TRUNC      = FFT_TRUNC
) (
  input  logic [DATA_WIDTH-1:0] a_real,
  input  logic [DATA_WIDTH-1:0] a_imag,
  input  logic [DATA_WIDTH-1:0] b_real,
  input  logic [DATA_WIDTH-1:0] b_imag,
  output logic [DATA_WIDTH-1:0] p_real,
  output logic [DATA_WIDTH-1:0] p_imag
);

  localparam int PW = 2 * DATA_WIDTH;

  logic signed [PW-1:0] rr, ii, ri, ir;
  logic signed [PW-1:0] full_real, full_imag;

  always_comb begin
    // Operands are sign-extended to full product width before multiplying.
    rr = PW'($signed(a_real)) * PW'($signed(b_real));
    ii = PW'($signed(a_imag)) * PW'($signed(b_imag));
    ri = PW'($signed(a_real)) * PW'($signed(b_imag));
    ir = PW'($signed(a_imag)) * PW'($signed(b_real));
    // Sum/difference wraps at PW bits; the result window is a plain slice.
    full_real = rr - ii;
    full_imag = ri + ir;
    p_real    = DATA_WIDTH'(full_real >>> TRUNC);
    p_imag    = DATA_WIDTH'(full_imag >>> TRUNC);
  end

endmodule

// File: rtl/cmul_arbiter.sv
// Round-robin arbiter sharing one complex multiplier between NUM_REQ requesters.
//   clk, rst             : clock and synchronous active-high reset
//   req_valid/req_ready  : per-requester handshake; req_ready is one-hot or zero
//   req_{a,b}_{real,imag}: packed operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_valid/out_ready  : result handshake
//   out_real/out_imag    : registered truncated product
//   out_id               : index of the requester that owns the result
// Pipeline: S1 registers the granted operands, the multiplier sits between S1
// and S2, S2 drives the outputs. Results leave in grant order.
module cmul_arbiter
  import fft_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = FFT_DATA_WIDTH,
  parameter  int TRUNC      = FFT_TRUNC,
  localparam int ID_W       = id_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_real,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_imag,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_real,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_imag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_real,
  output logic [DATA_WIDTH-1:0]         out_imag,
  output logic [ID_W-1:0]               out_id
);

  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic                  s1_valid_q, s1_valid_d;
  logic [ID_W-1:0]       s1_id_q, s1_id_d;
  logic [DATA_WIDTH-1:0] s1_ar_q, s1_ar_d, s1_ai_q, s1_ai_d;
  logic [DATA_WIDTH-1:0] s1_br_q, s1_br_d, s1_bi_q, s1_bi_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [ID_W-1:0]       s2_id_q, s2_id_d;
  logic [DATA_WIDTH-1:0] s2_real_q, s2_real_d, s2_imag_q, s2_imag_d;

  logic                  s1_adv, s2_adv;
  logic                  found_hi, found_lo, any_valid, xfer;
  logic [ID_W-1:0]       idx_hi, idx_lo, grant_id;
  logic [DATA_WIDTH-1:0] prod_real, prod_imag;

  // S2 moves when its slot is free or being drained; S1 follows into an
  // empty or advancing S2, so a full pipe still sustains one result per cycle.
  assign s2_adv = !s2_valid_q || out_ready;
  assign s1_adv = !s1_valid_q || s2_adv;

  // Round-robin search split in two ascending scans: the lowest valid index at
  // or above the pointer wins, otherwise the lowest valid index below it.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i]) begin
        if (i >= int'(ptr_q)) begin
          if (!found_hi) begin
            found_hi = 1'b1;
            idx_hi   = ID_W'(i);
          end
        end else if (!found_lo) begin
          found_lo = 1'b1;
          idx_lo   = ID_W'(i);
        end
      end
    end
    any_valid = found_hi || found_lo;
    grant_id  = found_hi ? idx_hi : idx_lo;
  end

  always_comb begin
    req_ready = '0;
    if (!rst && s1_adv && any_valid) req_ready[grant_id] = 1'b1;
  end

  assign xfer = |(req_valid & req_ready);

  complex_multiplier #(
    .DATA_WIDTH (DATA_WIDTH),
    .TRUNC      (TRUNC)
  ) u_cmul (
    .a_real (s1_ar_q),
    .a_imag (s1_ai_q),
    .b_real (s1_br_q),
    .b_imag (s1_bi_q),
    .p_real (prod_real),
    .p_imag (prod_imag)
  );

  always_comb begin
    ptr_d      = ptr_q;
    s1_valid_d = s1_valid_q;
    s1_id_d    = s1_id_q;
    s1_ar_d    = s1_ar_q;
    s1_ai_d    = s1_ai_q;
    s1_br_d    = s1_br_q;
    s1_bi_d    = s1_bi_q;
    s2_valid_d = s2_valid_q;
    s2_id_d    = s2_id_q;
    s2_real_d  = s2_real_q;
    s2_imag_d  = s2_imag_q;

    if (xfer) begin
      ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    end

    if (s1_adv) begin
      s1_valid_d = xfer;
      if (xfer) begin
        s1_id_d = grant_id;
        s1_ar_d = req_a_real[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
        s1_ai_d = req_a_imag[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
        s1_br_d = req_b_real[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
        s1_bi_d = req_b_imag[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    // Output data only changes when a real result arrives, so it stays stable
    // across stalls and bubbles.
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_id_d   = s1_id_q;
        s2_real_d = prod_real;
        s2_imag_d = prod_imag;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_id_q    <= '0;
      s2_real_q  <= '0;
      s2_imag_q  <= '0;
    end else begin
      ptr_q      <= ptr_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s2_id_q    <= s2_id_d;
      s2_real_q  <= s2_real_d;
      s2_imag_q  <= s2_imag_d;
    end
  end

  // NOTE: S1 payload is qualified by s1_valid_q, so it carries no reset and
  // stays a plain datapath register.
  always_ff @(posedge clk) begin
    s1_id_q <= s1_id_d;
    s1_ar_q <= s1_ar_d;
    s1_ai_q <= s1_ai_d;
    s1_br_q <= s1_br_d;
    s1_bi_q <= s1_bi_d;
  end

  assign out_valid = s2_valid_q;
  assign out_id    = s2_id_q;
  assign out_real  = s2_real_q;
  assign out_imag  = s2_imag_q;

endmodule

// File: tb/tb_cmul_arbiter.sv
// Directed self-checking bench for cmul_arbiter (NUM_REQ=4, DATA_WIDTH=16,
// TRUNC=8). Inputs change 1 time unit after posedge; outputs are sampled on
// the falling edge.
module tb_cmul_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] a_r, a_i, b_r, b_i;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_real, out_imag;
  logic [1:0]  out_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cmul_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (16),
    .TRUNC      (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a_real (a_r),
    .req_a_imag (a_i),
    .req_b_real (b_r),
    .req_b_imag (b_i),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_real   (out_real),
    .out_imag   (out_imag),
    .out_id     (out_id)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [15:0] ar, input logic [15:0] ai,
                        input logic [15:0] br, input logic [15:0] bi);
    a_r[i*16 +: 16] = ar;
    a_i[i*16 +: 16] = ai;
    b_r[i*16 +: 16] = br;
    b_i[i*16 +: 16] = bi;
  endtask

  // One isolated operation on requester idx; pointer must already select it.
  task automatic run_op(input int idx, input logic [15:0] ar, input logic [15:0] ai,
                        input logic [15:0] br, input logic [15:0] bi,
                        input logic [15:0] er, input logic [15:0] ei);
    set_op(idx, ar, ai, br, bi);
    req_valid = 4'b0001 << idx;
    @(negedge clk);
    check("op_ready", 32'(req_ready), 32'(4'b0001 << idx));
    cyc();                                   // transfer edge
    req_valid = 4'b0000;
    @(negedge clk);
    check("op_lat1_valid", 32'(out_valid), 32'd0);
    cyc();
    @(negedge clk);
    check("op_lat2_valid", 32'(out_valid), 32'd1);
    check("op_real", 32'(out_real), 32'(er));
    check("op_imag", 32'(out_imag), 32'(ei));
    check("op_id", 32'(out_id), 32'(idx));
    cyc();                                   // consumed here
    @(negedge clk);
    check("op_drained", 32'(out_valid), 32'd0);
    cyc();
  endtask

  initial begin
    // Reset state, with requests asserted to show ready stays low.
    rst       = 1'b1;
    req_valid = 4'b1111;
    out_ready = 1'b1;
    a_r = '0; a_i = '0; b_r = '0; b_i = '0;
    cyc();
    cyc();
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_real", 32'(out_real), 32'd0);
    check("rst_out_imag", 32'(out_imag), 32'd0);
    check("rst_out_id", 32'(out_id), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    cyc();
    rst       = 1'b0;
    req_valid = 4'b0000;

    // Single and complex operations: (256,0)^2, (256+256j)^2, (-256)*(256j).
    run_op(0, 16'h0100, 16'h0000, 16'h0100, 16'h0000, 16'h0100, 16'h0000);
    run_op(1, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0000, 16'h0200);
    run_op(3, 16'hff00, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'hff00);

    // Sparse: pointer is 0. Req 2 alone wins, idle leaves pointer at 3,
    // then {2,1} valid -> search 3,0,1 picks 1.
    set_op(2, 16'h0100, 16'h0000, 16'h0000, 16'h0100);
    req_valid = 4'b0100;
    @(negedge clk);
    check("sparse_g2", 32'(req_ready), 32'b0100);
    cyc();
    req_valid = 4'b0000;
    @(negedge clk);
    check("sparse_idle", 32'(req_ready), 32'd0);
    cyc();
    req_valid = 4'b0110;
    @(negedge clk);
    check("sparse_g1", 32'(req_ready), 32'b0010);
    check("sparse_out2_id", 32'(out_id), 32'd2);
    check("sparse_out2_imag", 32'(out_imag), 32'h0100);
    cyc();
    req_valid = 4'b0000;
    @(negedge clk);
    check("sparse_bubble", 32'(out_valid), 32'd0);
    cyc();
    @(negedge clk);
    check("sparse_out1_id", 32'(out_id), 32'd1);
    check("sparse_out1_imag", 32'(out_imag), 32'h0200);
    cyc();

    // Contention: requester i multiplies (256*(i+1)) by 256 -> real 256*(i+1).
    for (int i = 0; i < 4; i++) set_op(i, 16'(256 * (i + 1)), 16'h0000, 16'h0100, 16'h0000);
    rst       = 1'b1;
    req_valid = 4'b1111;
    @(negedge clk);
    check("rst_ready_hold", 32'(req_ready), 32'd0);
    cyc();
    rst = 1'b0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      check("cont_grant", 32'(req_ready), 32'(4'b0001 << (c % 4)));
      if (c >= 2) begin
        check("cont_valid", 32'(out_valid), 32'd1);
        check("cont_id", 32'(out_id), 32'((c - 2) % 4));
        check("cont_real", 32'(out_real), 32'(256 * (((c - 2) % 4) + 1)));
      end else begin
        check("cont_fill", 32'(out_valid), 32'd0);
      end
      cyc();
    end

    // Backpressure: output holds id 1 (transferred 2 cycles earlier), S1 holds
    // id 2, pointer is 3.
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check("bp_ready", 32'(req_ready), 32'd0);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_id", 32'(out_id), 32'd1);
      check("bp_real", 32'(out_real), 32'd512);
      cyc();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("rel_id1", 32'(out_id), 32'd1);
    check("rel_grant3", 32'(req_ready), 32'b1000);
    cyc();
    @(negedge clk);
    check("rel_id2", 32'(out_id), 32'd2);
    check("rel_real2", 32'(out_real), 32'd768);
    check("rel_grant0", 32'(req_ready), 32'b0001);
    cyc();
    @(negedge clk);
    check("rel_id3", 32'(out_id), 32'd3);
    check("rel_real3", 32'(out_real), 32'd1024);
    check("rel_grant1", 32'(req_ready), 32'b0010);
    cyc();

    // Reset mid-op: id 0 at the output, id 1 in S1, pointer 2.
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ptr0", 32'(req_ready), 32'b0001);
    cyc();
    req_valid = 4'b0000;
    @(negedge clk);
    check("mid_no_stale", 32'(out_valid), 32'd0);
    cyc();
    @(negedge clk);
    check("mid_new_valid", 32'(out_valid), 32'd1);
    check("mid_new_id", 32'(out_id), 32'd0);
    check("mid_new_real", 32'(out_real), 32'd256);
    cyc();
    @(negedge clk);
    check("mid_empty", 32'(out_valid), 32'd0);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
